gf_mult_feeder: RTL and testbench

//  Upstream driver for the bit-serial GF(2^m) multiplier (gf_mult).

---
 rtl/gf_pkg.sv | 21 ++
 rtl/gf_res_buf.sv | 65 ++++++
 rtl/gf_mult_feeder.sv | 132 +++++++++++++
 tb/tb_gf_mult_feeder.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gf_pkg.sv
// Shared definitions for the GF(2^m) multiplier feeder: field size, primitive polynomial,
// feeder state encoding and the bit-counter width helper.
package gf_pkg;

  localparam int         GF_M         = 8;
  localparam logic [7:0] GF_PRIM_POLY = 8'h1D;  // x^8+x^4+x^3+x^2+1, x^8 implied

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLR   = 2'd1,
    SHIFT = 2'd2,
    WAIT  = 2'd3
  } feed_state_e;

  function automatic int k_width(input int m);
    return (m > 1) ? $clog2(m) : 1;
  endfunction

  localparam int GF_K_W = k_width(GF_M);

endpackage

// File: rtl/gf_res_buf.sv
// Two-entry synchronous FIFO holding multiplier products; head is a register so the
// consumer sees a stable value, and it keeps the last popped value when empty.
module gf_res_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [1:0]   count,
  output logic [W-1:0] head
);

  logic [W-1:0] head_q, head_d;
  logic [W-1:0] tail_q, tail_d;
  logic [1:0]   count_q, count_d;
  logic         do_push;
  logic         do_pop;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    do_pop  = pop && (count_q != 2'd0);
    do_push = push && ((count_q != 2'd2) || do_pop);
    case ({do_push, do_pop})
      2'b10: begin
        if (count_q == 2'd0) head_d = din;
        else                 tail_d = din;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        // Popping the only entry leaves head untouched so it retains the last value.
        if (count_q == 2'd2) head_d = tail_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          head_d = din;
        end else begin
          head_d = tail_q;
          tail_d = din;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign head  = head_q;

endmodule

// File: rtl/gf_mult_feeder.sv
// Drives the bit-serial GF(2^m) multiplier: clear, shift symbol MSB-first, capture product
// into a 2-entry result buffer. Optional product counter enabled by GF_FEED_CNT_EN.
module gf_mult_feeder
  import gf_pkg::*;
#(
  parameter int M = GF_M
`ifdef GF_FEED_CNT_EN
  ,
  parameter int CNT_W = 16
`endif
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [M-1:0] sym_in,
  input  logic         sym_valid,
  output logic         sym_ready,
  output logic         mult_clr,
  output logic         b_out,
  input  logic [M-1:0] prod_in,
  output logic [M-1:0] res_data,
  output logic         res_valid,
  input  logic         res_ready
`ifdef GF_FEED_CNT_EN
  ,
  output logic [CNT_W-1:0] prod_cnt
`endif
);

  localparam int KW = k_width(M);

  feed_state_e   state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [M-1:0]  shreg_q, shreg_d;
  logic [1:0]    buf_count;
  logic          buf_push;
  logic          buf_pop;
  logic          ready_raw;

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    shreg_d   = shreg_q;
    ready_raw = 1'b0;
    mult_clr  = 1'b0;
    b_out     = 1'b0;
    buf_push  = 1'b0;
    case (state_q)
      IDLE: begin
        ready_raw = (buf_count < 2'd2);
        if (sym_valid && ready_raw) begin
          shreg_d = sym_in;
          state_d = CLR;
        end
      end
      CLR: begin
        mult_clr = 1'b1;
        k_d      = '0;
        state_d  = SHIFT;
      end
      SHIFT: begin
        // Shifting left keeps the next operand bit at the MSB.
        b_out   = shreg_q[M-1];
        shreg_d = shreg_q << 1;
        k_d     = k_q + KW'(1);
        if (k_q == KW'(M - 1)) state_d = WAIT;
      end
      WAIT: begin
        buf_push  = 1'b1;
        ready_raw = (buf_count == 2'd0) || ((buf_count == 2'd1) && res_ready);
        if (sym_valid && ready_raw) begin
          shreg_d = sym_in;
          state_d = CLR;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (reset) begin
      ready_raw = 1'b0;
      mult_clr  = 1'b1;
      b_out     = 1'b0;
      buf_push  = 1'b0;
    end
  end

  assign sym_ready = ready_raw;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      k_q     <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      shreg_q <= shreg_d;
    end
  end

  assign res_valid = !reset && (buf_count != 2'd0);
  assign buf_pop   = res_valid && res_ready;

  gf_res_buf #(
    .W(M)
  ) u_res_buf (
    .clk   (clk),
    .reset (reset),
    .push  (buf_push),
    .din   (prod_in),
    .pop   (buf_pop),
    .count (buf_count),
    .head  (res_data)
  );

`ifdef GF_FEED_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (buf_push) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign prod_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_gf_mult_feeder.sv
// Bench for gf_mult_feeder with a behavioural bit-serial multiplier (a=8'h02, poly 8'h1D).
// Define GF_FEED_CNT_EN to also exercise the product counter at CNT_W=2.
module tb_gf_mult_feeder;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] sym_in;
  logic       sym_valid;
  logic       sym_ready;
  logic       mult_clr;
  logic       b_out;
  logic [7:0] prod_in;
  logic [7:0] res_data;
  logic       res_valid;
  logic       res_ready;
`ifdef GF_FEED_CNT_EN
  logic [1:0] prod_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;

  logic [7:0] exp_q[$];
  int         pop_q[$];
  logic [7:0] c_q;

  gf_mult_feeder #(
    .M(8)
`ifdef GF_FEED_CNT_EN
    ,
    .CNT_W(2)
`endif
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .sym_in    (sym_in),
    .sym_valid (sym_valid),
    .sym_ready (sym_ready),
    .mult_clr  (mult_clr),
    .b_out     (b_out),
    .prod_in   (prod_in),
    .res_data  (res_data),
    .res_valid (res_valid),
    .res_ready (res_ready)
`ifdef GF_FEED_CNT_EN
    ,
    .prod_cnt  (prod_cnt)
`endif
  );

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc_n++;
  end

  // Bit-serial multiplier model: c = c*x + b*a, MSB-first, cleared by mult_clr.
  always_ff @(posedge clk) begin
    if (mult_clr) c_q <= 8'h00;
    else          c_q <= {c_q[6:0], 1'b0} ^ (c_q[7] ? 8'h1D : 8'h00) ^ (b_out ? 8'h02 : 8'h00);
  end
  assign prod_in = c_q;

  function automatic logic [7:0] gfmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      r = {r[6:0], 1'b0} ^ (r[7] ? 8'h1D : 8'h00);
      if (b[i]) r = r ^ a;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Scoreboard: push on accept, pop/compare on consumer handshake.
  initial forever begin
    @(negedge clk);
    if (!reset && sym_valid && sym_ready) exp_q.push_back(gfmul(8'h02, sym_in));
    if (!reset && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_result", {24'h0, res_data}, 32'hFFFF_FFFF);
      end else begin
        chk("sb_result", {24'h0, res_data}, {24'h0, exp_q.pop_front()});
        pop_q.push_back(cyc_n);
      end
      $display("result %02h at cycle %0d", res_data, cyc_n);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Offer one symbol until accepted; returns the cycle number of the accept edge.
  task automatic offer(input logic [7:0] s, input string tag, output int acc);
    int n;
    sym_in    = s;
    sym_valid = 1'b1;
    n = 0;
    while (!sym_ready && n < 60) begin
      cyc();
      n++;
    end
    chk(tag, n < 60, 1);
    acc = cyc_n;
    cyc();
    sym_valid = 1'b0;
    $display("sym %02h accepted at cycle %0d", s, acc);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      cyc();
      n++;
    end
    chk(tag, exp_q.size(), 0);
  endtask

  int acc[3];
  int dummy;
  int rdy_seen;

  initial begin
    reset     = 1'b1;
    sym_in    = 8'h00;
    sym_valid = 1'b0;
    res_ready = 1'b0;

    // 1. reset
    repeat (3) cyc();
    chk("rst_mult_clr", mult_clr, 1);
    chk("rst_sym_ready", sym_ready, 0);
    reset = 1'b0;
    #0;
    chk("idle_res_valid", res_valid, 0);
    chk("idle_mult_clr", mult_clr, 0);
    chk("idle_sym_ready", sym_ready, 1);
    chk("idle_res_data", res_data, 0);
`ifdef GF_FEED_CNT_EN
    chk("idle_prod_cnt", prod_cnt, 0);
`endif

    // 2. single symbol, b_out sequence and latency
    sym_in    = 8'h01;
    sym_valid = 1'b1;
    cyc();
    sym_valid = 1'b0;
    chk("t2_clr_mult_clr", mult_clr, 1);
    chk("t2_clr_b_out", b_out, 0);
    for (int i = 0; i < 8; i++) begin
      sym_in = 8'($urandom);
      cyc();
      chk($sformatf("t2_b_out_%0d", i), b_out, (i == 7) ? 1 : 0);
    end
    cyc();
    chk("t2_wait_res_valid", res_valid, 0);
    chk("t2_wait_mult_clr", mult_clr, 0);
    cyc();
    chk("t2_lat_res_valid", res_valid, 1);
    chk("t2_lat_res_data", res_data, 8'h02);
    cyc();
    chk("t2_hold_res_data", res_data, 8'h02);
    res_ready = 1'b1;
    cyc();
    res_ready = 1'b0;
    chk("t2_empty_res_valid", res_valid, 0);
    chk("t2_empty_res_data", res_data, 8'h02);

    // 3. back-to-back with consumer always ready
    res_ready = 1'b1;
    pop_q.delete();
    offer(8'h80, "t3_accept0", acc[0]);
    offer(8'h00, "t3_accept1", acc[1]);
    offer(8'h53, "t3_accept2", acc[2]);
    drain("t3_drain");
    chk("t3_acc_gap01", acc[1] - acc[0], 10);
    chk("t3_acc_gap12", acc[2] - acc[1], 10);
    chk("t3_pop_count", pop_q.size(), 3);
    if (pop_q.size() == 3) begin
      chk("t3_res_gap01", pop_q[1] - pop_q[0], 10);
      chk("t3_res_gap12", pop_q[2] - pop_q[1], 10);
    end

    // 4. back-pressure: buffer fills, third symbol waits for a pop
    res_ready = 1'b0;
    offer(8'h35, "t4_accept0", dummy);
    offer(8'hC7, "t4_accept1", dummy);
    sym_in    = 8'h9E;
    sym_valid = 1'b1;
    rdy_seen  = 0;
    repeat (20) begin
      cyc();
      if (sym_ready) rdy_seen++;
    end
    chk("t4_blocked", rdy_seen, 0);
    chk("t4_full_res_valid", res_valid, 1);
    chk("t4_full_head", res_data, gfmul(8'h02, 8'h35));
    res_ready = 1'b1;
    chk("t4_pulse_sym_ready", sym_ready, 0);
    cyc();
    res_ready = 1'b0;
    chk("t4_after_pop_sym_ready", sym_ready, 1);
    cyc();
    sym_valid = 1'b0;
    chk("t4_third_clr", mult_clr, 1);
    res_ready = 1'b1;
    drain("t4_drain");
    cyc();

    // 5. reset in the middle of SHIFT discards everything
    res_ready = 1'b0;
    offer(8'h11, "t5_accept0", dummy);
    repeat (12) cyc();
    chk("t5_buffered", res_valid, 1);
    offer(8'hFF, "t5_accept1", dummy);
    repeat (5) cyc();
    chk("t5_shift_k4_b_out", b_out, 1);
    reset = 1'b1;
    exp_q.delete();
    cyc();
    chk("t5_rst_mult_clr", mult_clr, 1);
    chk("t5_rst_res_valid", res_valid, 0);
    reset = 1'b0;
    #0;
    chk("t5_idle_sym_ready", sym_ready, 1);
    chk("t5_empty_res_valid", res_valid, 0);
    chk("t5_empty_res_data", res_data, 0);
    chk("t5_idle_mult_clr", mult_clr, 0);
    res_ready = 1'b1;
    offer(8'h01, "t5_accept2", dummy);
    drain("t5_drain");
    chk("t5_last_res_data", res_data, 8'h02);

`ifdef GF_FEED_CNT_EN
    // 6. counter wraps at CNT_W=2
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    #0;
    chk("t6_cnt_reset", prod_cnt, 0);
    for (int i = 0; i < 5; i++) begin
      offer(8'(8'h21 + i), $sformatf("t6_accept%0d", i), dummy);
      drain($sformatf("t6_drain%0d", i));
      chk($sformatf("t6_prod_cnt_%0d", i), prod_cnt, (i + 1) % 4);
    end
`endif

    chk("final_queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
